pulse_train_gen: RTL and testbench

Programmable pulse-train source: the transmit-side counterpart of the pulse-duration counter. It drives a trigger line whose high and low durations are set in ticks of a clock-enable strobe, so that the counter reads back the programmed values (count_p = high_len, count_m = low_len). It is used for self-test and calibration of the ADC trigger and measurement path. It sits on the main clock domain, fed by the divide-by-6 strobe and a register-interface configuration port.

---
 rtl/pulse_train_gen_pkg.sv | 13 +
 rtl/pulse_train_gen_if.sv | 24 ++
 rtl/pulse_train_gen_phase_timer.sv | 35 +++
 rtl/pulse_train_gen.sv | 151 +++++++++++++++
 tb/tb_pulse_train_gen.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_train_gen_pkg.sv
// Shared types and defaults for the pulse-train generator.
package pulse_gen_pkg;

  localparam int unsigned WDefault      = 24;
  localparam int unsigned BurstWDefault = 16;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StHigh = 2'd1;
  localparam state_t StLow  = 2'd2;

endpackage

// File: rtl/pulse_train_gen_if.sv
// Configuration slot and train-control bundle of the pulse-train generator.
interface pulse_train_gen_if #(
  parameter int unsigned W       = 24,
  parameter int unsigned BURST_W = 16
);
  logic               cfg_valid;
  logic               cfg_ready;
  logic [W-1:0]       cfg_high;
  logic [W-1:0]       cfg_low;
  logic [BURST_W-1:0] cfg_burst;
  logic               start;
  logic               stop;
  logic               abort;

  modport master (
    output cfg_valid, cfg_high, cfg_low, cfg_burst, start, stop, abort,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_high, cfg_low, cfg_burst, start, stop, abort,
    output cfg_ready
  );
endinterface

// File: rtl/pulse_train_gen_phase_timer.sv
// Tick-enabled phase counter; wraps to zero by itself on the terminal tick.
module phase_timer #(
  parameter int unsigned W = 24
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] len_i,
  output logic [W-1:0] cnt_o,
  output logic         term_o
);
  logic [W-1:0] cnt_q, cnt_d;

  // len_i is already clamped to >= 1, so len_i - 1 never wraps.
  assign term_o = (cnt_q == len_i - W'(1));
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = term_o ? '0 : cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train source: high/low durations in tick units, finite or continuous bursts.
module pulse_train_gen
  import pulse_gen_pkg::*;
#(
  parameter int unsigned W       = WDefault,
  parameter int unsigned BURST_W = BurstWDefault
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               tick_i,
  pulse_train_gen_if.slave   cfg_if,
  output logic               trigger_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [BURST_W-1:0] period_cnt_o
);
  state_t             state_q, state_d;
  logic               pend_q, pend_d;
  logic [W-1:0]       pend_high_q, pend_low_q, act_high_q, act_low_q;
  logic [BURST_W-1:0] pend_burst_q, act_burst_q;
  logic               loaded_q;
  logic               stop_req_q, stop_req_d;
  logic               trigger_q, trigger_d;
  logic               done_q, done_d;
  logic [BURST_W-1:0] period_cnt_q, period_cnt_d;
  logic [BURST_W-1:0] period_inc;

  logic               cfg_hs, start_ok, copy, last_period;
  logic               timer_clr, timer_en, timer_term;
  logic [W-1:0]       len_sel, timer_len, timer_cnt;

  assign cfg_if.cfg_ready = ~pend_q;
  assign cfg_hs           = cfg_if.cfg_valid & ~pend_q;
  assign start_ok         = cfg_if.start & ~cfg_if.stop & ~cfg_if.abort & (pend_q | loaded_q);

  // A zero length is run as a single tick.
  assign len_sel   = (state_q == StLow) ? act_low_q : act_high_q;
  assign timer_len = (len_sel == '0) ? W'(1) : len_sel;
  assign timer_en  = tick_i & (state_q != StIdle);

  assign period_inc  = period_cnt_q + BURST_W'(1);
  assign last_period = (act_burst_q != '0) && (period_inc == act_burst_q);

  phase_timer #(
    .W (W)
  ) u_phase_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (timer_clr),
    .en_i   (timer_en),
    .len_i  (timer_len),
    .cnt_o  (timer_cnt),
    .term_o (timer_term)
  );

  always_comb begin
    state_d      = state_q;
    trigger_d    = trigger_q;
    done_d       = 1'b0;
    stop_req_d   = stop_req_q;
    period_cnt_d = period_cnt_q;
    copy         = 1'b0;
    timer_clr    = 1'b0;
    case (state_q)
      StHigh, StLow: begin
        if (cfg_if.abort) begin
          state_d    = StIdle;
          trigger_d  = 1'b0;
          stop_req_d = 1'b0;
          timer_clr  = 1'b1;
        end else begin
          if (cfg_if.stop) stop_req_d = 1'b1;
          if (tick_i && timer_term) begin
            if (state_q == StHigh) begin
              state_d   = StLow;
              trigger_d = 1'b0;
            end else begin
              period_cnt_d = (&period_cnt_q) ? period_cnt_q : period_inc;
              if (last_period || stop_req_d) begin
                state_d    = StIdle;
                done_d     = 1'b1;
                stop_req_d = 1'b0;
              end else begin
                state_d   = StHigh;
                trigger_d = 1'b1;
                copy      = 1'b1;
              end
            end
          end
        end
      end
      default: begin
        if (start_ok) begin
          state_d      = StHigh;
          trigger_d    = 1'b1;
          copy         = 1'b1;
          period_cnt_d = '0;
          timer_clr    = 1'b1;
        end
      end
    endcase
  end

  // A handshake coinciding with a copy lands after it, so pending stays set.
  always_comb begin
    pend_d = pend_q;
    if (copy) pend_d = 1'b0;
    if (cfg_hs) pend_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      trigger_q    <= 1'b0;
      done_q       <= 1'b0;
      stop_req_q   <= 1'b0;
      period_cnt_q <= '0;
      pend_q       <= 1'b0;
      loaded_q     <= 1'b0;
      pend_high_q  <= '0;
      pend_low_q   <= '0;
      pend_burst_q <= '0;
      act_high_q   <= '0;
      act_low_q    <= '0;
      act_burst_q  <= '0;
    end else begin
      state_q      <= state_d;
      trigger_q    <= trigger_d;
      done_q       <= done_d;
      stop_req_q   <= stop_req_d;
      period_cnt_q <= period_cnt_d;
      pend_q       <= pend_d;
      if (copy && pend_q) begin
        act_high_q  <= pend_high_q;
        act_low_q   <= pend_low_q;
        act_burst_q <= pend_burst_q;
        loaded_q    <= 1'b1;
      end
      if (cfg_hs) begin
        pend_high_q  <= cfg_if.cfg_high;
        pend_low_q   <= cfg_if.cfg_low;
        pend_burst_q <= cfg_if.cfg_burst;
      end
    end
  end

  assign trigger_o    = trigger_q;
  assign busy_o       = (state_q != StIdle);
  assign done_o       = done_q;
  assign period_cnt_o = period_cnt_q;
endmodule

// File: tb/tb_pulse_train_gen.sv
// Self-checking bench: measures trigger segment lengths in clks against tick-unit expectations.
module tb_pulse_train_gen;
  localparam int unsigned W       = 24;
  localparam int unsigned BW      = 16;
  localparam int          TickDiv = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tick = 1'b0;
  bit            tick_en = 1'b1;
  logic          trigger, busy, done;
  logic [BW-1:0] period_cnt;

  int            nvec = 0;
  int            nerr = 0;
  int            segs[$];
  bit            seg_done, seg_timeout;
  int            ready_bad;
  logic          done_busy;
  logic [BW-1:0] done_pcnt;

  pulse_train_gen_if #(.W(W), .BURST_W(BW)) bus ();

  pulse_train_gen #(
    .W       (W),
    .BURST_W (BW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tick_i       (tick),
    .cfg_if       (bus),
    .trigger_o    (trigger),
    .busy_o       (busy),
    .done_o       (done),
    .period_cnt_o (period_cnt)
  );

  always #5 clk = ~clk;

  initial begin : tick_gen
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        tick = (div == TickDiv - 1);
        div  = (div == TickDiv - 1) ? 0 : div + 1;
      end else begin
        tick = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference rule: a zero length runs as one tick; each tick is TickDiv clks.
  function automatic int exp_clks(input int len);
    return ((len == 0) ? 1 : len) * TickDiv;
  endfunction

  task automatic send_cfg(input int h, input int l, input int b);
    int guard;
    guard = 0;
    while (bus.cfg_ready !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    nvec++;
    if (bus.cfg_ready !== 1'b1) begin
      nerr++;
      $display("FAIL cfg_ready_wait: got %b, required 1", bus.cfg_ready);
    end
    bus.cfg_valid = 1'b1;
    bus.cfg_high  = W'(h);
    bus.cfg_low   = W'(l);
    bus.cfg_burst = BW'(b);
    @(negedge clk);
    bus.cfg_valid = 1'b0;
  endtask

  // Pulses start, then records every trigger segment length (clks) until done.
  task automatic measure(input int stop_seg, input int cfg_seg, input int nh, input int nl,
                         input int max_cyc);
    int   cnt, idx, cyc;
    logic prev;
    segs.delete();
    seg_done    = 1'b0;
    seg_timeout = 1'b0;
    ready_bad   = 0;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    prev = 1'b1;
    cnt  = 1;
    idx  = 0;
    cyc  = 0;
    if (trigger !== 1'b1) cyc = max_cyc;
    while (cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      bus.stop      = 1'b0;
      bus.cfg_valid = 1'b0;
      if (done === 1'b1) begin
        segs.push_back(cnt);
        seg_done  = 1'b1;
        done_busy = busy;
        done_pcnt = period_cnt;
        break;
      end
      if (trigger !== prev) begin
        segs.push_back(cnt);
        cnt  = 1;
        prev = trigger;
        idx++;
        if (idx == stop_seg) bus.stop = 1'b1;
        if (idx == cfg_seg) begin
          bus.cfg_valid = 1'b1;
          bus.cfg_high  = W'(nh);
          bus.cfg_low   = W'(nl);
          bus.cfg_burst = '0;
        end
        if (cfg_seg >= 0 && idx == cfg_seg + 2 && bus.cfg_ready !== 1'b1) ready_bad++;
      end else begin
        cnt++;
      end
      if (cfg_seg >= 0 && (idx == cfg_seg + 1 || (idx == cfg_seg && cnt > 1)) &&
          bus.cfg_ready !== 1'b0) ready_bad++;
    end
    if (!seg_done) seg_timeout = 1'b1;
  endtask

  task automatic test_reset();
    bus.cfg_valid = 1'b0;
    bus.cfg_high  = '0;
    bus.cfg_low   = '0;
    bus.cfg_burst = '0;
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    bus.abort     = 1'b0;
    #1;
    nvec++;
    if ({trigger, busy, done, period_cnt, bus.cfg_ready} !== {3'b000, BW'(0), 1'b1}) begin
      nerr++;
      $display("FAIL reset_values: got trig=%b busy=%b done=%b pcnt=%0d rdy=%b, required 0 0 0 0 1",
               trigger, busy, done, period_cnt, bus.cfg_ready);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    // Nothing has been loaded yet, so start must be ignored.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    nvec++;
    if (busy !== 1'b0 || trigger !== 1'b0) begin
      nerr++;
      $display("FAIL start_unloaded: got busy=%b trig=%b, required 0 0", busy, trigger);
    end
  endtask

  task automatic test_burst(input int h, input int l, input int b);
    int exp;
    send_cfg(h, l, b);
    measure(-1, -1, 0, 0, (exp_clks(h) + exp_clks(l)) * (b + 1) + 100);
    nvec++;
    if (seg_timeout || segs.size() != 2 * b) begin
      nerr++;
      $display("FAIL burst_segments h=%0d l=%0d b=%0d: got %0d segs timeout=%b, required %0d",
               h, l, b, segs.size(), seg_timeout, 2 * b);
    end
    for (int i = 1; i < segs.size(); i++) begin
      exp = (i % 2 == 1) ? exp_clks(l) : exp_clks(h);
      nvec++;
      if (segs[i] != exp) begin
        nerr++;
        $display("FAIL burst_seg%0d h=%0d l=%0d: got %0d clks, required %0d", i, h, l, segs[i], exp);
      end
    end
    if (seg_done) begin
      nvec++;
      if (done_busy !== 1'b0 || done_pcnt !== BW'(b)) begin
        nerr++;
        $display("FAIL burst_done_state: got busy=%b pcnt=%0d, required 0 %0d",
                 done_busy, done_pcnt, b);
      end
    end
    @(negedge clk);
    nvec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL done_single_pulse: got done=%b busy=%b, required 0 0", done, busy);
    end
  endtask

  task automatic test_loopback();
    int exp;
    send_cfg(1000, 250, 0);
    measure(4, -1, 0, 0, 6 * 1250 * 4);
    nvec++;
    if (seg_timeout || segs.size() != 6 || done_pcnt !== BW'(3)) begin
      nerr++;
      $display("FAIL loopback_run: got %0d segs pcnt=%0d, required 6 segs pcnt=3",
               segs.size(), done_pcnt);
    end
    for (int i = 1; i < segs.size(); i++) begin
      exp = (i % 2 == 1) ? exp_clks(250) : exp_clks(1000);
      nvec++;
      if (segs[i] != exp) begin
        nerr++;
        $display("FAIL loopback_seg%0d: got %0d clks, required %0d", i, segs[i], exp);
      end
    end
  endtask

  task automatic test_cfg_update();
    int exp_tick[8];
    exp_tick = '{3, 2, 3, 2, 7, 2, 7, 2};
    send_cfg(3, 2, 0);
    measure(6, 2, 7, 2, 2000);
    nvec++;
    if (seg_timeout || segs.size() != 8 || done_pcnt !== BW'(4)) begin
      nerr++;
      $display("FAIL cfg_update_run: got %0d segs pcnt=%0d, required 8 segs pcnt=4",
               segs.size(), done_pcnt);
    end
    for (int i = 1; i < segs.size() && i < 8; i++) begin
      nvec++;
      if (segs[i] != exp_clks(exp_tick[i])) begin
        nerr++;
        $display("FAIL cfg_update_seg%0d: got %0d clks, required %0d",
                 i, segs[i], exp_clks(exp_tick[i]));
      end
    end
    nvec++;
    if (ready_bad != 0) begin
      nerr++;
      $display("FAIL cfg_ready_window: got %0d bad samples, required 0", ready_bad);
    end
  endtask

  task automatic test_abort_and_idle_stop();
    int guard, done_seen;
    logic [BW-1:0] pcnt_hold;
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      nerr++;
      $display("FAIL stop_in_idle: got busy=%b done=%b, required 0 0", busy, done);
    end
    send_cfg(4, 3, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    nvec++;
    if (trigger !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || period_cnt !== BW'(0)) begin
      nerr++;
      $display("FAIL abort_next_clk: got trig=%b busy=%b done=%b pcnt=%0d, required 0 0 0 0",
               trigger, busy, done, period_cnt);
    end
    pcnt_hold = period_cnt;
    done_seen = 0;
    for (guard = 0; guard < 40; guard++) begin
      @(negedge clk);
      if (done === 1'b1 || busy !== 1'b0 || period_cnt !== pcnt_hold) done_seen++;
    end
    nvec++;
    if (done_seen != 0) begin
      nerr++;
      $display("FAIL abort_quiet: got %0d bad samples, required 0", done_seen);
    end
  endtask

  task automatic test_tick_freeze();
    int bad, guard;
    send_cfg(2, 2, 1);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    tick_en = 1'b0;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (trigger !== 1'b1 || busy !== 1'b1 || done !== 1'b0) bad++;
    end
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL tick_freeze: got %0d bad samples, required 0", bad);
    end
    tick_en = 1'b1;
    guard = 0;
    while (done !== 1'b1 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    nvec++;
    if (done !== 1'b1 || period_cnt !== BW'(1)) begin
      nerr++;
      $display("FAIL freeze_resume: got done=%b pcnt=%0d, required 1 1", done, period_cnt);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midlow();
    int guard, bad;
    send_cfg(4, 3, 0);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    guard = 0;
    while (trigger !== 1'b0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    repeat (5) @(negedge clk);
    nvec++;
    if (busy !== 1'b1 || trigger !== 1'b0) begin
      nerr++;
      $display("FAIL reach_low: got busy=%b trig=%b, required 1 0", busy, trigger);
    end
    bus.start = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if ({trigger, busy, done, period_cnt, bus.cfg_ready} !== {3'b000, BW'(0), 1'b1}) begin
      nerr++;
      $display("FAIL async_reset: got trig=%b busy=%b done=%b pcnt=%0d rdy=%b, required 0 0 0 0 1",
               trigger, busy, done, period_cnt, bus.cfg_ready);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy !== 1'b0 || trigger !== 1'b0) bad++;
    end
    bus.start = 1'b0;
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL idle_after_reset: got %0d busy samples, required 0", bad);
    end
  endtask

  initial begin : main
    int h, l, b;
    test_reset();
    test_burst(5, 3, 4);
    test_loopback();
    test_burst(0, 0, 2);
    test_cfg_update();
    test_abort_and_idle_stop();
    test_tick_freeze();
    for (int k = 0; k < 6; k++) begin
      h = int'($urandom_range(0, 5));
      l = int'($urandom_range(0, 5));
      b = int'($urandom_range(1, 3));
      test_burst(h, l, b);
    end
    test_reset_midlow();
    test_burst(2, 1, 1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
